// File: rtl/softmax_mul_arbiter_if.sv
// softmax_mul_arbiter_if: requester, response and multiplier signals around the shared-multiplier arbiter.
interface softmax_mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int BW   = 32
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_a;
    logic [NREQ*BW-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [AW+BW-1:0]   rsp_p;
    logic               rsp_err;
    logic               mul_start;
    logic [AW-1:0]      mul_a;
    logic [BW-1:0]      mul_b;
    logic               mul_busy;
    logic               mul_done;
    logic [AW+BW-1:0]   mul_p;
    logic               spurious_err;
    modport slave (
        input  req_valid, req_a, req_b, mul_busy, mul_done, mul_p,
        output req_ready, rsp_valid, rsp_id, rsp_p, rsp_err, mul_start, mul_a, mul_b, spurious_err
    );
    modport master (
        output req_valid, req_a, req_b, mul_busy, mul_done, mul_p,
        input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_err, mul_start, mul_a, mul_b, spurious_err
    );
endinterface

// File: rtl/softmax_mul_arbiter.sv
// softmax_mul_arbiter: round-robin sharing of one start/done signed multiplier between NREQ requesters,
// with a watchdog that turns a hung multiplier into an error response.
module softmax_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int BW      = 32,
    parameter int TIMEOUT = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    softmax_mul_arbiter_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW  = $clog2(TIMEOUT) + 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d, g_q, g_d, rsp_id_q, rsp_id_d, pick, jj;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic [NREQ-1:0]  ready_q, ready_d;
    logic [AW-1:0]    a_q, a_d;
    logic [BW-1:0]    b_q, b_d;
    logic [AW+BW-1:0] rsp_p_q, rsp_p_d;
    logic             start_q, start_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, spur_q, spur_d;
    logic             found;
    int               j;
    // Scan from the farthest offset down so the nearest requester after last wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        j     = 0;
        jj    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j  = int'(last_q) + 1 + i;
            j  = (j >= NREQ) ? j - NREQ : j;
            jj = IDW'(j);
            if (bus.req_valid[jj]) begin
                found = 1'b1;
                pick  = jj;
            end
        end
    end
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        g_d         = g_q;
        wdog_d      = wdog_q;
        a_d         = a_q;
        b_d         = b_q;
        ready_d     = '0;
        start_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_p_d     = rsp_p_q;
        rsp_err_d   = rsp_err_q;
        spur_d      = spur_q | (bus.mul_done & (state_q != WAIT));
        case (state_q)
            IDLE: if (found) begin
                a_d     = bus.req_a[pick*AW +: AW];
                b_d     = bus.req_b[pick*BW +: BW];
                g_d     = pick;
                ready_d = NREQ'(1) << pick;
                state_d = ISSUE;
            end
            ISSUE: if (!bus.mul_busy) begin
                start_d = 1'b1;
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wdog_d = wdog_q + 1'b1;
                // A done arriving on the timeout cycle still counts as a good result.
                if (bus.mul_done || wdog_q == WW'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = g_q;
                    rsp_err_d   = !bus.mul_done;
                    rsp_p_d     = bus.mul_done ? bus.mul_p : '0;
                    last_d      = g_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IDW'(NREQ - 1);
            g_q         <= '0;
            wdog_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ready_q     <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_p_q     <= '0;
            rsp_err_q   <= 1'b0;
            spur_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            g_q         <= g_d;
            wdog_q      <= wdog_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ready_q     <= ready_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_p_q     <= rsp_p_d;
            rsp_err_q   <= rsp_err_d;
            spur_q      <= spur_d;
        end
    end
    assign bus.req_ready    = ready_q;
    assign bus.mul_start    = start_q;
    assign bus.mul_a        = a_q;
    assign bus.mul_b        = b_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_p        = rsp_p_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.spurious_err = spur_q;
endmodule
